ms_uart_tx_sched: RTL and testbench
===================================

Name: ms_uart_tx_sched

Overview:
Transmit-side controller that drains the UART TX FIFO into the UART transmitter, one frame at a time. It issues FIFO read strobes, captures the registered FIFO output and hands each byte to the transmitter with a start/busy handshake. It also supports a software flush, a stuck-transmitter timeout, and a drain-complete interrupt pulse. It sits between the TX FIFO instance and the transmitter shift engine.

Parameters:
DWIDTH, 8, data byte width; must match the FIFO DWIDTH.
CWIDTH, 16, width of the sent-frame counter SENT_CNT.
ACK_TIMEOUT, 64, cycles allowed for TX_BUSY to rise after TX_START; must be ≥ 2.

Ports:
CLK  in  1  clock; all logic on the rising edge.
RESETN  in  1  synchronous, active-low reset.
EN  in  1  scheduler enable; level-sensitive.
FLUSH  in  1  request to discard FIFO contents; level, sampled in IDLE.
FIFO_EMPTY  in  1  TX FIFO empty flag.
FIFO_DOUT  in  DWIDTH  TX FIFO read data; valid the cycle after FIFO_RD.
FIFO_RD  out  1  FIFO pop strobe; one cycle wide.
TX_BUSY  in  1  transmitter busy; high while a frame is shifting.
TX_START  out  1  one-cycle start strobe to the transmitter.
TX_DATA  out  DWIDTH  byte to transmit; held stable from START until TX_BUSY falls.
SENT_CNT  out  CWIDTH  count of frames completed; wraps modulo 2^CWIDTH.
SCHED_IDLE  out  1  high when the FSM is in IDLE.
DONE_IRQ  out  1  one-cycle pulse when the FIFO drains after at least one frame.
TO_ERR  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset values (RESETN=0 at a clock edge): state IDLE, FIFO_RD=0, TX_START=0, TX_DATA=0, SENT_CNT=0, SCHED_IDLE=1, DONE_IRQ=0, TO_ERR=0, internal had_frame=0, timeout counter=0. Reset mid-frame aborts immediately; the byte held in TX_DATA is lost.
- FSM states: IDLE, POP, LATCH, START, WAIT_BUSY, WAIT_DONE, FLUSH_POP, FLUSH_CHK.
- IDLE: FLUSH has priority.
  - FLUSH=1 and FIFO_EMPTY=0 -> FLUSH_POP.
  - Else if EN=1, FIFO_EMPTY=0 and TX_BUSY=0 -> POP.
  - Otherwise stay in IDLE.
- POP: FIFO_RD=1 for exactly this cycle -> LATCH.
- LATCH: TX_DATA <= FIFO_DOUT -> START.
- START: TX_START=1 for exactly this cycle; timeout counter cleared -> WAIT_BUSY.
- WAIT_BUSY:
  - TX_BUSY=1 -> WAIT_DONE.
  - Otherwise the counter increments. When it reaches ACK_TIMEOUT-1 with TX_BUSY still 0: TO_ERR <= 1, the byte is dropped, SENT_CNT is not incremented -> IDLE.
- WAIT_DONE: on TX_BUSY=0, SENT_CNT <= SENT_CNT+1 and had_frame <= 1 -> IDLE.
- Minimum frame-to-frame spacing: POP→LATCH→START plus transmitter time. Latency from the IDLE decision to TX_START is 3 cycles.
- DONE_IRQ: pulses one cycle in IDLE when EN=1, FIFO_EMPTY=1 and had_frame=1; had_frame is cleared in the same cycle. It does not pulse after a flush-only sequence.
- Flush:
  - FLUSH_POP: FIFO_RD=1 -> FLUSH_CHK.
  - FLUSH_CHK: no strobe; this lets the registered EMPTY flag settle.
  - From FLUSH_CHK: FIFO_EMPTY=0 and FLUSH=1 -> FLUSH_POP; else -> IDLE.
  - Flushed bytes do not touch TX_DATA or SENT_CNT.
- EN dropped mid-frame: the current frame completes through WAIT_DONE; no new POP while EN=0. FLUSH still works with EN=0.
- FIFO_RD is never asserted while FIFO_EMPTY=1 in the same cycle.
- FIFO_RD and TX_START are never both high.
- SCHED_IDLE is a combinational decode of the state.

Optional Feature:
MS_UART_TX_GAP_EN: when defined, adds input GAP_CYCLES [7:0] and state GAP, inserted between WAIT_DONE and IDLE. GAP holds for GAP_CYCLES cycles (0 means skip GAP) before returning to IDLE, giving an inter-frame idle time for slow receivers. SENT_CNT increments on entry to GAP. Without the macro, the port and state are absent and WAIT_DONE goes directly to IDLE.

Decomposition:
- Shared package ms_uart_pkg holds:
  - state enum / localparams for the FSM encodings;
  - the default DWIDTH;
  - the ACK_TIMEOUT default.
- One natural sub-module: ms_uart_tx_tmr, a loadable down-counter. It is used for the WAIT_BUSY timeout and is reused for the GAP count when MS_UART_TX_GAP_EN is defined.

Test Plan:
- Single byte: FIFO holds 0xA5, EN=1, transmitter model raises TX_BUSY 2 cycles after TX_START for 10 cycles -> FIFO_RD at T, TX_DATA=0xA5 at T+1, TX_START at T+2, SENT_CNT=1, DONE_IRQ one pulse after TX_BUSY falls.
- Burst: FIFO holds 0x11,0x22,0x33 -> three TX_START strobes in order with matching TX_DATA, SENT_CNT=3, exactly one DONE_IRQ pulse.
- Timeout: TX_BUSY tied 0, one byte queued -> TO_ERR=1 after ACK_TIMEOUT cycles in WAIT_BUSY, SENT_CNT=0, FSM back in IDLE; TO_ERR remains 1 until RESETN=0.
- Flush: FIFO holds 4 bytes, EN=0, FLUSH=1 -> exactly 4 FIFO_RD pulses spaced 2 cycles apart, TX_START never asserted, SENT_CNT=0, DONE_IRQ=0.
- EN drop / reset: EN falls during WAIT_DONE with 2 bytes queued -> the current frame completes, SENT_CNT+1, no further FIFO_RD. Separately, RESETN=0 during WAIT_BUSY -> all outputs at reset values on the next cycle.
- Gap (macro defined): GAP_CYCLES=5, 2 bytes queued -> 5 idle cycles between TX_BUSY falling and the second FIFO_RD. GAP_CYCLES=0 gives the same timing as without the macro.

Source files
------------

// File: rtl/ms_uart_pkg.sv
// Shared types and defaults for the UART TX scheduler slice.
// Optional MS_UART_TX_GAP_EN adds the GAP state used for inter-frame spacing.
package ms_uart_pkg;

    localparam int DWIDTH_DEF      = 8;
    localparam int ACK_TIMEOUT_DEF = 64;
    localparam int GAP_W           = 8;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_POP       = 4'd1,
        ST_LATCH     = 4'd2,
        ST_START     = 4'd3,
        ST_WAIT_BUSY = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_FLUSH_POP = 4'd6,
        ST_FLUSH_CHK = 4'd7
`ifdef MS_UART_TX_GAP_EN
        ,
        ST_GAP       = 4'd8
`endif
    } sched_state_e;

    // The timer holds either the ack timeout or an 8-bit gap count, whichever is wider.
    function automatic int tmr_width(input int ack_timeout);
        int w;
        w = $clog2(ack_timeout);
        return (w > GAP_W) ? w : GAP_W;
    endfunction

endpackage

// File: rtl/ms_uart_tx_sched_if.sv
// FIFO-side and transmitter-side signals of the TX scheduler.
// Handshake: FIFO_RD pops one entry whose data appears on FIFO_DOUT next cycle;
// TX_START is a one-cycle strobe, TX_BUSY high marks the frame in flight.
interface ms_uart_tx_sched_if
    import ms_uart_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
);
    logic              FIFO_EMPTY;
    logic [DWIDTH-1:0] FIFO_DOUT;
    logic              FIFO_RD;
    logic              TX_BUSY;
    logic              TX_START;
    logic [DWIDTH-1:0] TX_DATA;

    modport master (
        input  FIFO_EMPTY, FIFO_DOUT, TX_BUSY,
        output FIFO_RD, TX_START, TX_DATA
    );

    modport slave (
        output FIFO_EMPTY, FIFO_DOUT, TX_BUSY,
        input  FIFO_RD, TX_START, TX_DATA
    );
endinterface

// File: rtl/ms_uart_tx_tmr.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module ms_uart_tx_tmr #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/ms_uart_tx_sched.sv
// Drains the TX FIFO into the transmitter one frame at a time, with flush,
// stuck-transmitter timeout and drain-complete pulse. Option: MS_UART_TX_GAP_EN.
module ms_uart_tx_sched
    import ms_uart_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int CWIDTH      = 16,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                EN,
    input  logic                FLUSH,
`ifdef MS_UART_TX_GAP_EN
    input  logic [GAP_W-1:0]    GAP_CYCLES,
`endif
    ms_uart_tx_sched_if.master  bus,
    output logic [CWIDTH-1:0]   SENT_CNT,
    output logic                SCHED_IDLE,
    output logic                DONE_IRQ,
    output logic                TO_ERR,
    output sched_state_e        dbg_state_o
);
    localparam int TMR_W = tmr_width(ACK_TIMEOUT);

    sched_state_e      state_q, state_d;
    logic [DWIDTH-1:0] tx_data_q, tx_data_d;
    logic [CWIDTH-1:0] sent_cnt_q, sent_cnt_d;
    logic              had_frame_q, had_frame_d;
    logic              to_err_q, to_err_d;

    logic              fifo_rd, tx_start, done_irq;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]  tmr_load_val;

    ms_uart_tx_tmr #(.WIDTH(TMR_W)) u_tmr (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (FLUSH && !bus.FIFO_EMPTY) begin
                    state_d = ST_FLUSH_POP;
                end else if (EN && !bus.FIFO_EMPTY && !bus.TX_BUSY) begin
                    state_d = ST_POP;
                end
            end
            ST_POP:       state_d = ST_LATCH;
            ST_LATCH:     state_d = ST_START;
            ST_START:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.TX_BUSY) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.TX_BUSY) begin
`ifdef MS_UART_TX_GAP_EN
                    state_d = (GAP_CYCLES != '0) ? ST_GAP : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_FLUSH_POP: state_d = ST_FLUSH_CHK;
            ST_FLUSH_CHK: state_d = (FLUSH && !bus.FIFO_EMPTY) ? ST_FLUSH_POP : ST_IDLE;
`ifdef MS_UART_TX_GAP_EN
            ST_GAP:       if (tmr_zero) state_d = ST_IDLE;
`endif
            default:      state_d = ST_IDLE;
        endcase
    end

    // The timer is preloaded with ACK_TIMEOUT-1 so expiry lands on the last allowed WAIT_BUSY cycle.
    always_comb begin
        tx_data_d    = tx_data_q;
        sent_cnt_d   = sent_cnt_q;
        had_frame_d  = had_frame_q;
        to_err_d     = to_err_q;
        fifo_rd      = 1'b0;
        tx_start     = 1'b0;
        done_irq     = 1'b0;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (EN && bus.FIFO_EMPTY && had_frame_q) begin
                    done_irq    = 1'b1;
                    had_frame_d = 1'b0;
                end
            end
            ST_POP, ST_FLUSH_POP: fifo_rd = !bus.FIFO_EMPTY;
            ST_LATCH:             tx_data_d = bus.FIFO_DOUT;
            ST_START: begin
                tx_start     = 1'b1;
                tmr_load     = 1'b1;
                tmr_load_val = TMR_W'(ACK_TIMEOUT - 1);
            end
            ST_WAIT_BUSY: begin
                if (!bus.TX_BUSY) begin
                    tmr_dec = 1'b1;
                    if (tmr_zero) to_err_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.TX_BUSY) begin
                    sent_cnt_d  = sent_cnt_q + 1'b1;
                    had_frame_d = 1'b1;
`ifdef MS_UART_TX_GAP_EN
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(GAP_CYCLES) - 1'b1;
`endif
                end
            end
`ifdef MS_UART_TX_GAP_EN
            ST_GAP:  tmr_dec = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            tx_data_q   <= '0;
            sent_cnt_q  <= '0;
            had_frame_q <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            tx_data_q   <= tx_data_d;
            sent_cnt_q  <= sent_cnt_d;
            had_frame_q <= had_frame_d;
            to_err_q    <= to_err_d;
        end
    end

    assign bus.FIFO_RD  = fifo_rd;
    assign bus.TX_START = tx_start;
    assign bus.TX_DATA  = tx_data_q;
    assign SENT_CNT     = sent_cnt_q;
    assign SCHED_IDLE   = (state_q == ST_IDLE);
    assign DONE_IRQ     = done_irq;
    assign TO_ERR       = to_err_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_ms_uart_tx_sched.sv
// Directed bench for ms_uart_tx_sched: FIFO and transmitter models, a TX_START
// scoreboard fed by the stimulus, and directed checks of counters and timing.
`timescale 1ns/1ps
module tb_ms_uart_tx_sched;
    import ms_uart_pkg::*;

    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int ACK = 64;

    // clock / reset
    logic CLK    = 1'b0;
    logic RESETN = 1'b0;
    logic EN     = 1'b0;
    logic FLUSH  = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [CW-1:0] SENT_CNT;
    logic          SCHED_IDLE, DONE_IRQ, TO_ERR;
    sched_state_e  dbg_state;
`ifdef MS_UART_TX_GAP_EN
    logic [7:0]    gap_cycles = 8'd0;
`endif

    ms_uart_tx_sched_if #(.DWIDTH(DW)) bus ();

    ms_uart_tx_sched #(.DWIDTH(DW), .CWIDTH(CW), .ACK_TIMEOUT(ACK)) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .EN          (EN),
        .FLUSH       (FLUSH),
`ifdef MS_UART_TX_GAP_EN
        .GAP_CYCLES  (gap_cycles),
`endif
        .bus         (bus),
        .SENT_CNT    (SENT_CNT),
        .SCHED_IDLE  (SCHED_IDLE),
        .DONE_IRQ    (DONE_IRQ),
        .TO_ERR      (TO_ERR),
        .dbg_state_o (dbg_state)
    );

    // FIFO model: registered data and empty flag
    logic [DW-1:0] fifo_q[$];
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout  = '0;
    assign bus.FIFO_EMPTY = fifo_empty;
    assign bus.FIFO_DOUT  = fifo_dout;

    always @(posedge CLK) begin
        if (bus.FIFO_RD && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // transmitter model: busy 2 cycles after start, for 10 cycles
    logic tx_busy  = 1'b0;
    bit   tx_stuck = 1'b0;
    int   busy_fall_cyc = -1;
    assign bus.TX_BUSY = tx_busy;

    initial begin
        forever begin
            @(negedge CLK);
            if (bus.TX_START && !tx_stuck) begin
                repeat (2) @(posedge CLK);
                #1 tx_busy = 1'b1;
                repeat (10) @(posedge CLK);
                #1 tx_busy = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] cur_byte = '0;
    logic [DW-1:0] exp_byte;
    int rd_cyc[$];
    int start_cnt = 0;
    int start_cyc = -1;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int to_cyc    = -1;
    logic to_prev = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (RESETN) begin
            if (bus.FIFO_RD) begin
                rd_cyc.push_back(cyc);
                chk("rd_while_empty", fifo_empty, 1'b0);
                chk("rd_with_start", bus.TX_START, 1'b0);
            end
            if (bus.TX_START) begin
                start_cnt++;
                start_cyc = cyc;
                chk("start_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_byte = exp_q.pop_front();
                    cur_byte = exp_byte;
                    chk("tx_data_at_start", bus.TX_DATA, exp_byte);
                end
            end
            if (tx_busy) chk("tx_data_hold", bus.TX_DATA, cur_byte);
            if (DONE_IRQ) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (TO_ERR && !to_prev) to_cyc = cyc;
        end
        to_prev = TO_ERR;
    end

    // driver tasks
    task automatic drive_edge;
        @(posedge CLK);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_stats;
        rd_cyc.delete();
        start_cnt = 0;
        start_cyc = -1;
        done_cnt  = 0;
        done_cyc  = -1;
        to_cyc    = -1;
    endtask

    task automatic do_reset;
        drive_edge();
        RESETN = 1'b0;
        EN     = 1'b0;
        FLUSH  = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        repeat (2) drive_edge();
        RESETN = 1'b1;
        clear_stats();
    endtask

    task automatic push_byte(input logic [DW-1:0] b, input bit expect_tx);
        fifo_q.push_back(b);
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_fifo_rd"}, bus.FIFO_RD, 1'b0);
        chk({tag, "_tx_start"}, bus.TX_START, 1'b0);
        chk({tag, "_tx_data"}, bus.TX_DATA, 0);
        chk({tag, "_sent_cnt"}, SENT_CNT, 0);
        chk({tag, "_sched_idle"}, SCHED_IDLE, 1'b1);
        chk({tag, "_done_irq"}, DONE_IRQ, 1'b0);
        chk({tag, "_to_err"}, TO_ERR, 1'b0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset values
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_vals("reset");
        drive_edge();
        RESETN = 1'b1;

        // single byte
        clear_stats();
        EN = 1'b1;
        push_byte(8'hA5, 1'b1);
        tick(40);
        chk("single_rd_count", rd_cyc.size(), 1);
        chk("single_start_after_rd", start_cyc - ((rd_cyc.size() > 0) ? rd_cyc[0] : -100), 2);
        chk("single_sent_cnt", SENT_CNT, 1);
        chk("single_done_count", done_cnt, 1);
        chk("single_done_after_fall", done_cyc - busy_fall_cyc, 1);
        chk("single_exp_drained", exp_q.size(), 0);
        chk("single_idle", SCHED_IDLE, 1'b1);

        // burst of three
        do_reset();
        EN = 1'b1;
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        tick(100);
        chk("burst_rd_count", rd_cyc.size(), 3);
        chk("burst_start_count", start_cnt, 3);
        chk("burst_sent_cnt", SENT_CNT, 3);
        chk("burst_done_count", done_cnt, 1);
        chk("burst_exp_drained", exp_q.size(), 0);

        // stuck transmitter timeout
        do_reset();
        tx_stuck = 1'b1;
        EN = 1'b1;
        push_byte(8'h3C, 1'b1);
        tick(100);
        chk("to_err_set", TO_ERR, 1'b1);
        chk("to_latency", to_cyc - start_cyc, ACK + 1);
        chk("to_sent_cnt", SENT_CNT, 0);
        chk("to_idle", dbg_state, ST_IDLE);
        chk("to_no_done", done_cnt, 0);
        tick(20);
        chk("to_err_sticky", TO_ERR, 1'b1);
        do_reset();
        tx_stuck = 1'b0;
        @(negedge CLK);
        chk("to_err_cleared", TO_ERR, 1'b0);

        // flush with EN low
        do_reset();
        FLUSH = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i), 1'b0);
        tick(30);
        chk("flush_rd_count", rd_cyc.size(), 4);
        for (int i = 0; i + 1 < rd_cyc.size(); i++) chk("flush_rd_spacing", rd_cyc[i + 1] - rd_cyc[i], 2);
        chk("flush_no_start", start_cnt, 0);
        chk("flush_sent_cnt", SENT_CNT, 0);
        chk("flush_fifo_empty", fifo_q.size(), 0);
        drive_edge();
        FLUSH = 1'b0;
        EN = 1'b1;
        tick(5);
        chk("flush_no_done", done_cnt, 0);

        // EN dropped during WAIT_DONE
        do_reset();
        EN = 1'b1;
        push_byte(8'h5A, 1'b1);
        push_byte(8'h6B, 1'b0);
        n = 0;
        while (!tx_busy && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("endrop_busy_seen", tx_busy, 1'b1);
        drive_edge();
        EN = 1'b0;
        tick(30);
        chk("endrop_sent_cnt", SENT_CNT, 1);
        chk("endrop_rd_count", rd_cyc.size(), 1);
        chk("endrop_fifo_left", fifo_q.size(), 1);
        chk("endrop_no_done", done_cnt, 0);
        chk("endrop_idle", SCHED_IDLE, 1'b1);

        // reset during WAIT_BUSY
        tx_stuck = 1'b1;
        exp_q.push_back(8'h6B);
        drive_edge();
        EN = 1'b1;
        n = 0;
        while (start_cnt < 2 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("midrst_start_seen", start_cnt, 2);
        @(negedge CLK);
        chk("midrst_in_wait_busy", dbg_state, ST_WAIT_BUSY);
        drive_edge();
        RESETN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_reset_vals("midrst");
        drive_edge();
        RESETN = 1'b1;
        tx_stuck = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
